// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg                                                              |
// | Opcode encoding, FSM state encoding and opcode-class helpers.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_muldiv_iter                                                      |
// | Bit-serial shift-add multiplier / restoring divider on magnitudes.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_kill,
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH);

  logic               r_run;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg;
  logic               r_hi;
  logic               r_rem_sel;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;  // multiplier, or dividend shifting into quotient
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvsr;

  logic             w_sa, w_sb;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo, w_rmd;

  assign w_sa    = (i_op == OP_MULH || i_op == OP_MULHSU || i_op == OP_DIV || i_op == OP_REM)
                   && i_a[WIDTH-1];
  assign w_sb    = (i_op == OP_MULH || i_op == OP_DIV || i_op == OP_REM) && i_b[WIDTH-1];
  assign w_mag_a = w_sa ? -i_a : i_a;
  assign w_mag_b = w_sb ? -i_b : i_b;

  assign w_shift = {r_rem, r_mplier[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvsr};

  always_ff @(posedge clk) begin
    if (rst || i_kill) begin
      r_run     <= 1'b0;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_hi      <= 1'b0;
      r_rem_sel <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_dvsr    <= '0;
    end else if (i_start) begin
      r_run     <= 1'b1;
      r_cnt     <= CNT_W'(WIDTH - 1);
      r_is_div  <= is_div(i_op);
      // Remainder follows the dividend; everything else follows the sign product
      r_neg     <= (i_op == OP_REM) ? w_sa : (w_sa ^ w_sb);
      r_hi      <= (i_op == OP_MULH || i_op == OP_MULHSU || i_op == OP_MULHU);
      r_rem_sel <= (i_op == OP_REM || i_op == OP_REMU);
      r_acc     <= '0;
      r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
      r_mplier  <= is_div(i_op) ? w_mag_a : w_mag_b;
      r_rem     <= '0;
      r_dvsr    <= w_mag_b;
    end else if (r_run) begin
      if (r_is_div) begin
        if (!w_diff[WIDTH]) begin
          r_rem    <= w_diff[WIDTH-1:0];
          r_mplier <= {r_mplier[WIDTH-2:0], 1'b1};
        end else begin
          r_rem    <= w_shift[WIDTH-1:0];
          r_mplier <= {r_mplier[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = r_run && (r_cnt == '0);

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_mplier : r_mplier;
  assign w_rmd  = r_neg ? -r_rem : r_rem;

  assign o_result = r_is_div ? (r_rem_sel ? w_rmd : w_quo)
                             : (r_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0]);

endmodule
`default_nettype wire

// File: rtl/alu_mc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mc_pipe                                                          |
// | Execute-stage ALU: single-cycle ops plus iterative mul/div, kill.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_mc_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t           r_state, w_state_next;
  logic [TAG_W-1:0] r_tag;

  logic               w_accept, w_ovf, w_fast, w_multi, w_last;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_alu_result, w_md_result;

  assign w_shamt  = in_b[SHAMT_W-1:0];
  assign w_ovf    = (in_op == OP_DIV || in_op == OP_REM)
                    && (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == {WIDTH{1'b1}});
  assign w_fast   = is_div(in_op) && ((in_b == '0) || w_ovf);
  assign w_multi  = is_muldiv(in_op) && !w_fast;
  assign in_ready = (r_state == ST_IDLE) && (!out_valid || out_ready) && !kill;
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state == ST_ITER) || (r_state == ST_DONE);

  always_comb begin
    w_alu_result = '0;
    case (in_op)
      OP_ADD:  w_alu_result = in_a + in_b;
      OP_SUB:  w_alu_result = in_a - in_b;
      OP_AND:  w_alu_result = in_a & in_b;
      OP_OR:   w_alu_result = in_a | in_b;
      OP_XOR:  w_alu_result = in_a ^ in_b;
      OP_SLL:  w_alu_result = in_a << w_shamt;
      OP_SRL:  w_alu_result = in_a >> w_shamt;
      OP_SRA:  w_alu_result = $signed(in_a) >>> w_shamt;
      OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: w_alu_result = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      // Divide fast paths: zero divisor and most-negative / -1
      OP_DIV:  w_alu_result = (in_b == '0) ? {WIDTH{1'b1}} : in_a;
      OP_DIVU: w_alu_result = {WIDTH{1'b1}};
      OP_REM:  w_alu_result = (in_b == '0) ? in_a : '0;
      OP_REMU: w_alu_result = in_a;
      default: w_alu_result = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept && w_multi),
    .i_kill   (kill),
    .i_op     (in_op),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_last   (w_last),
    .o_result (w_md_result)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_multi) w_state_next = ST_ITER;
      ST_ITER: if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (kill) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      r_tag      <= '0;
    end else begin
      if (w_accept && w_multi) r_tag <= in_tag;
      if (kill) begin
        out_valid <= 1'b0;
      end else if (r_state == ST_DONE) begin
        out_valid  <= 1'b1;
        out_result <= w_md_result;
        out_tag    <= r_tag;
      end else if (w_accept && !w_multi) begin
        out_valid  <= 1'b1;
        out_result <= w_alu_result;
        out_tag    <= in_tag;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_mc_pipe                                                       |
// | Directed self-checking bench for alu_mc_pipe at WIDTH=32.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_mc_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_mc_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
    total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd1);
    step();
    total++; if (out_valid !== 1'b1 || out_result !== 32'h8000_0000 || out_tag !== 5'd1) begin
      bad++; $display("FAIL b2b_add got v=%0b r=%h t=%0d exp v=1 r=80000000 t=1", out_valid, out_result, out_tag); end
    drive(OP_SUB, 32'h0, 32'h1, 5'd2);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%0b exp=1", in_ready); end
    step();
    total++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFF || out_tag !== 5'd2) begin
      bad++; $display("FAIL b2b_sub got v=%0b r=%h t=%0d exp v=1 r=ffffffff t=2", out_valid, out_result, out_tag); end
    in_valid = 1'b0; step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_shift_compare();
    logic [4:0]  ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    logic [31:0] exps [3];
    ops = '{OP_SRA, OP_SLT, OP_SLTU};
    as  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bs  = '{32'h0000_0024, 32'h1, 32'h1};
    exps = '{32'hF800_0000, 32'h1, 32'h0};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], as[i], bs[i], 5'(i + 3));
      step();
      total++; if (out_valid !== 1'b1 || out_result !== exps[i] || out_tag !== 5'(i + 3)) begin
        bad++; $display("FAIL shift_cmp[%0d] got v=%0b r=%h t=%0d exp r=%h t=%0d", i, out_valid, out_result, out_tag, exps[i], i + 3); end
    end
    in_valid = 1'b0; step();
  endtask

  // Issues one op and returns its latency in cycles counted from the accepting cycle
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output int lat, output logic stall_ok);
    drive(op, a, b, tag);
    step();
    in_valid = 1'b0;
    lat = 1;
    stall_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) stall_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic test_muldiv();
    logic [4:0]  ops [8];
    logic [31:0] as [8];
    logic [31:0] bs [8];
    logic [31:0] exps [8];
    int          lats [8];
    int          lat;
    logic        stall_ok;
    ops  = '{OP_MUL, OP_MULHU, OP_MULH, OP_DIV, OP_REM, OP_DIVU, OP_REM, OP_MULHSU};
    as   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'h7, 32'h8000_0000, 32'hFFFF_FFFF};
    bs   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'h2,
             32'h0, 32'hFFFF_FFFF, 32'h2};
    exps = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
             32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    lats = '{34, 34, 34, 34, 34, 1, 1, 34};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i + 10), lat, stall_ok);
      total++; if (out_result !== exps[i] || out_tag !== 5'(i + 10)) begin
        bad++; $display("FAIL muldiv_result[%0d] got r=%h t=%0d exp r=%h t=%0d", i, out_result, out_tag, exps[i], i + 10); end
      total++; if (lat != lats[i]) begin
        bad++; $display("FAIL muldiv_latency[%0d] got=%0d exp=%0d", i, lat, lats[i]); end
      if (lats[i] > 1) begin
        total++; if (stall_ok !== 1'b1) begin
          bad++; $display("FAIL muldiv_busy_stall[%0d] got=%0b exp=1", i, stall_ok); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    out_ready = 1'b0;
    drive(OP_ADD, 32'h1, 32'h1, 5'd7);
    step();
    total++; if (out_valid !== 1'b1 || out_result !== 32'h2 || out_tag !== 5'd7) begin
      bad++; $display("FAIL bp_first got v=%0b r=%h t=%0d exp v=1 r=2 t=7", out_valid, out_result, out_tag); end
    drive(OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd8);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h2 || out_tag !== 5'd7) ok = 1'b0;
      step();
    end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_hold got=%0b exp=1", ok); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
    step();
    total++; if (out_valid !== 1'b1 || out_result !== 32'h0F0F_F0F0 || out_tag !== 5'd8) begin
      bad++; $display("FAIL bp_next got v=%0b r=%h t=%0d exp v=1 r=0f0ff0f0 t=8", out_valid, out_result, out_tag); end
    in_valid = 1'b0; step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_single_accept got=%0b exp=0", out_valid); end
  endtask

  task automatic test_kill_and_reset();
    logic seen;
    out_ready = 1'b1;
    drive(OP_DIV, 32'd1000, 32'd7, 5'd20);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    drive(OP_ADD, 32'h5, 32'h6, 5'd21);
    kill = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL kill_in_ready_low got=%0b exp=0", in_ready); end
    step();
    kill = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL kill_after got rdy=%0b busy=%0b v=%0b exp rdy=1 busy=0 v=0", in_ready, busy, out_valid); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL kill_no_result got=%0b exp=0", seen); end
    // Leave a nonzero held result so the reset check is meaningful
    drive(OP_OR, 32'h1234_0000, 32'h0000_5678, 5'd22);
    step();
    drive(OP_MUL, 32'd123, 32'd456, 5'd23);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_iter got v=%0b r=%h t=%0d busy=%0b rdy=%0b exp 0 0 0 0 1",
                      out_valid, out_result, out_tag, busy, in_ready); end
    drive(OP_ADD, 32'd2, 32'd3, 5'd24);
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'd5 || out_tag !== 5'd24) begin
      bad++; $display("FAIL post_rst_add got v=%0b r=%h t=%0d exp v=1 r=5 t=24", out_valid, out_result, out_tag); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_discard got=%0b exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_shift_compare();
    test_muldiv();
    test_backpressure();
    test_kill_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mc_pipe.md
Name: alu_mc_pipe

Overview:
Parametrised successor to the current execute-stage ALU. It covers the RV32IM integer ops at configurable WIDTH on a single clock. It replaces the separate mul/div clock domains with an iterative multicycle mul/div engine behind a valid/ready handshake. It sits in the execute stage between the operand-forwarding mux and the writeback register, and supports a pipeline kill for branch flush.

Parameters:
WIDTH, 32, operand/result width (power of two, 8..64)
TAG_W, 5, width of the opaque tag (destination register index) carried with each op
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from in_b (derived, not overridden)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operation presented
in_ready  out  1  block can accept this cycle
in_op  in  5  opcode (alu_pkg encoding)
in_a  in  WIDTH  operand 1 / dividend / multiplicand
in_b  in  WIDTH  operand 2 / divisor / shift amount in [SHAMT_W-1:0]
in_tag  in  TAG_W  tag returned with the result
kill  in  1  flush: abort any in-flight op and drop any held result
out_valid  out  1  result held
out_ready  in  1  consumer takes result
out_result  out  WIDTH  result
out_tag  out  TAG_W  tag of result
busy  out  1  multicycle op in progress

Behaviour:
- Opcodes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, MUL 10, MULH 11, MULHSU 12, MULHU 13, DIV 14, DIVU 15, REM 16, REMU 17. Codes 18..31 produce result 0 with latency 1.
- Reset: state IDLE, out_valid 0, out_result 0, out_tag 0, busy 0, in_ready 1.
- Accept when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready) && !kill.
- FSM states: IDLE, ITER, DONE.
  - IDLE: single-cycle op accepted at cycle t -> out_valid=1 at t+1 with the result registered; state stays IDLE.
  - IDLE: mul/div op accepted -> ITER, counter=WIDTH-1.
  - ITER: one bit per cycle. Mul is shift-add on magnitudes over 2*WIDTH. Div is restoring division. At counter 0 -> DONE.
  - DONE: sign-fix the result, load the output register, out_valid=1 -> IDLE.
  - Mul/div result is visible at t+WIDTH+2; busy is high in ITER and DONE.
- Signed ops: operate on magnitudes. MULH/MULHSU negate the 2*WIDTH product if signs differ. DIV quotient is negative if signs differ. REM takes the dividend's sign.
- Div fast paths, handled in IDLE with latency 1 and no ITER:
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> dividend.
  - Signed overflow (a = most negative, b = -1): DIV -> a; REM -> 0.
- Shifts use in_b[SHAMT_W-1:0] only; SRA sign-fills.
- SLT/SLTU return 1 or 0 zero-extended. Add/sub wrap modulo 2^WIDTH.
- Output register holds value and tag stable while out_valid && !out_ready.
- Back-to-back: a result consumed and a new op accepted in the same cycle is legal; there is no bubble for single-cycle ops.
- kill: next edge clears out_valid, returns to IDLE, clears busy. The op presented with kill is not accepted. kill has priority over every other event.
- rst mid-ITER: identical to reset; the partial result is discarded.

Decomposition:
- alu_pkg holds:
  - opcode localparams
  - state encoding (IDLE/ITER/DONE)
  - helper function is_muldiv(op)
- One sub-module, alu_muldiv_iter, owns:
  - the ITER datapath: accumulator, shifted operands, bit counter, sign flags
  - its start/done pulse interface
- alu_mc_pipe keeps the handshake, FSM, single-cycle datapath and output register.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+1 and SUB 0-1 back-to-back with out_ready=1 -> 0x80000000 at t+1, 0xFFFFFFFF at t+2; in_ready stays 1; tags echoed.
- SRA 0x80000000 by in_b=0x24 (shamt 4) -> 0xF8000000; SLT -1,1 -> 1; SLTU -1,1 -> 0.
- MUL 0xFFFFFFFF*0xFFFFFFFF, then MULHU same, then MULH same:
  - results 0x00000001, 0xFFFFFFFE, 0x00000000
  - each arrives exactly 34 cycles after acceptance
  - busy high and in_ready low throughout
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF at t+1; REM 0x80000000/-1 -> 0 at t+1.
- Backpressure: out_ready=0 for 5 cycles after a result -> out_result/out_tag stable, in_ready=0; raising out_ready with in_valid accepts the next op in the same cycle.
- kill at cycle 10 of a DIV, then rst asserted during a later MUL:
  - no out_valid after kill
  - in_ready=1 the cycle after kill
  - after rst all outputs equal reset values
  - a subsequent ADD 2+3 returns 5.
